// File: rtl/macguffin_dec.sv
// MacGuffin block decryptor: iterative, one inverse Feistel round per cycle,
// round keys expanded once after reset into an internal register file.
module macguffin_dec #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [63:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [63:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready
);

  localparam int            CW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  // Eight 6-in/2-out S-boxes, entry n at bits [2n+1:2n]; shared with the encryptor.
  localparam logic [127:0] SBOX [8] = '{
    128'he4d1_2fb8_3a6c_5907_b1e8_4d2f_c703_6a95,
    128'h1f6a_c9e2_7d40_b853_62ad_f01c_9b37_e4c5,
    128'ha72c_40f9_de15_836b_5c9e_0b71_f3a4_28d6,
    128'h7d3b_e960_0af5_2c18_b4e7_1d92_6c08_f53a,
    128'h2e4c_b17a_90d3_6f85_d8a1_4b2e_075c_93f6,
    128'hc6f0_1b9d_5a27_e384_3f6e_a0d9_b215_7c48,
    128'h4b96_7e2d_f310_a5c8_e017_9c4b_5d3a_86f2,
    128'hd825_6cb1_3e9f_0a47_91c3_f75e_2a60_4db8
  };

  typedef enum logic [1:0] {KEYGEN, IDLE, ROUND, OUT} state_t;

  function automatic logic [15:0] f_fn(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [47:0] k);
    logic [47:0] x;
    logic [15:0] y;
    logic [6:0]  idx;
    x = {a, b, c} ^ k;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      idx          = {x[6*j +: 6], 1'b0};
      y[2*j +: 2]  = SBOX[j][idx +: 2];
    end
    return y;
  endfunction

  // Key schedule: rotate left by 29, fold in F of the state and the step index.
  function automatic logic [127:0] ks_next(input logic [127:0] s, input logic [CW-1:0] j);
    return {s[98:0], s[127:99]} ^ {f_fn(s[127:112], s[111:96], s[95:80], s[47:0]), 112'(j)};
  endfunction

  function automatic logic [47:0] rk_of(input logic [127:0] s);
    return s[127:80] ^ s[47:0];
  endfunction

  // Inverse round: rotate words right, then r0 ^= F(r1, r2, r3, k).
  function automatic logic [63:0] inv_round(input logic [63:0] b, input logic [47:0] k);
    logic [63:0] r;
    r = {b[15:0], b[63:16]};
    return {r[63:48] ^ f_fn(r[47:32], r[31:16], r[15:0], k), r[47:0]};
  endfunction

  state_t        state;
  logic [CW-1:0] kcnt;
  logic [CW-1:0] rcnt;
  logic [127:0]  ks;
  logic [63:0]   blk;
  logic [47:0]   rkeys [ROUNDS];

  logic [127:0]  ks_cur;
  logic [CW-1:0] kidx;
  logic [63:0]   blk_next;

  // The key port is only looked at on the first expansion step.
  assign ks_cur   = (kcnt == '0) ? key : ks;
  assign kidx     = LAST - rcnt;
  assign blk_next = inv_round(blk, rkeys[kidx]);

  // NOTE: the round-key file has no reset; every entry is rewritten during KEYGEN before it is read.
  always_ff @(posedge clk) begin
    if (!rst && state == KEYGEN) rkeys[kcnt] <= rk_of(ks_cur);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (rst) begin
      state         <= KEYGEN;
      kcnt          <= '0;
      rcnt          <= '0;
      ks            <= '0;
      blk           <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      case (state)
        KEYGEN: begin
          ks <= ks_next(ks_cur, kcnt);
          if (kcnt == LAST) begin
            state         <= IDLE;
            s_axis_tready <= 1'b1;
          end else begin
            kcnt <= kcnt + 1'b1;
          end
        end
        IDLE: begin
          if (s_axis_tvalid) begin
            blk           <= s_axis_tdata;
            rcnt          <= '0;
            state         <= ROUND;
            s_axis_tready <= 1'b0;
          end
        end
        ROUND: begin
          blk <= blk_next;
          if (rcnt == LAST) begin
            state         <= OUT;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= blk_next;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
          end
        end
        default: state <= KEYGEN;
      endcase
    end
  end

endmodule

// File: tb/tb_macguffin_dec.sv
// Bench for macguffin_dec: a behavioural MacGuffin encryptor produces ciphertext,
// and the decryptor must return the original plaintext with the right timing.
module tb_macguffin_dec;

  localparam int ROUNDS = 32;

  localparam logic [127:0] SBOX [8] = '{
    128'he4d1_2fb8_3a6c_5907_b1e8_4d2f_c703_6a95,
    128'h1f6a_c9e2_7d40_b853_62ad_f01c_9b37_e4c5,
    128'ha72c_40f9_de15_836b_5c9e_0b71_f3a4_28d6,
    128'h7d3b_e960_0af5_2c18_b4e7_1d92_6c08_f53a,
    128'h2e4c_b17a_90d3_6f85_d8a1_4b2e_075c_93f6,
    128'hc6f0_1b9d_5a27_e384_3f6e_a0d9_b215_7c48,
    128'h4b96_7e2d_f310_a5c8_e017_9c4b_5d3a_86f2,
    128'hd825_6cb1_3e9f_0a47_91c3_f75e_2a60_4db8
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic [63:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic        idle_ready = 1'b0;
  logic [47:0] bk [ROUNDS];

  always #5 clk = ~clk;

  macguffin_dec #(.ROUNDS(ROUNDS)) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [47:0] k);
    logic [47:0]  x;
    logic [15:0]  y;
    logic [127:0] t;
    int           e;
    x = {a, b, c} ^ k;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      t          = SBOX[j];
      e          = int'(x[6*j +: 6]);
      y[2*j]     = t[2*e];
      y[2*j + 1] = t[2*e + 1];
    end
    return y;
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [127:0] s;
    s = k;
    for (int j = 0; j < ROUNDS; j++) begin
      bk[j] = s[127:80] ^ s[47:0];
      s = {s[98:0], s[127:99]} ^ {model_f(s[127:112], s[111:96], s[95:80], s[47:0]), 112'(j)};
    end
  endtask

  // Forward cipher: r0 ^= F(r1,r2,r3,K[i]), then rotate words left.
  function automatic logic [63:0] enc(input logic [63:0] p);
    logic [15:0] w [4];
    logic [15:0] t;
    for (int n = 0; n < 4; n++) w[n] = p[63 - 16*n -: 16];
    for (int i = 0; i < ROUNDS; i++) begin
      w[0] = w[0] ^ model_f(w[1], w[2], w[3], bk[i]);
      t = w[0]; w[0] = w[1]; w[1] = w[2]; w[2] = w[3]; w[3] = t;
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic do_reset(input logic [127:0] k);
    @(negedge clk);
    rst = 1'b1; key = k; s_axis_tvalid = 1'b0; m_axis_tready = idle_ready;
    @(negedge clk);
    rst = 1'b0;
    expand(k);
  endtask

  // Counts cycles with s_axis_tready low after reset; scrambles key once it has been sampled.
  task automatic wait_keygen(input string name);
    int n = 0;
    bit vseen = 1'b0;
    while (!s_axis_tready && n < 100) begin
      if (m_axis_tvalid) vseen = 1'b1;
      @(negedge clk);
      n++;
      if (n == 1) key = {$urandom, $urandom, $urandom, $urandom};
    end
    checks++;
    if (n !== ROUNDS) begin
      errors++; $display("FAIL %s keygen_len: got %0d cycles, expected %0d", name, n, ROUNDS);
    end
    checks++;
    if (vseen) begin
      errors++; $display("FAIL %s keygen_tvalid: got m_axis_tvalid=1, expected 0", name);
    end
  endtask

  task automatic send_block(input logic [63:0] d);
    int w = 0;
    while (!s_axis_tready && w < 200) begin @(negedge clk); w++; end
    if (!s_axis_tready) begin
      checks++; errors++; $display("FAIL send_timeout: s_axis_tready=0 after %0d cycles, expected 1", w);
      return;
    end
    s_axis_tdata = d; s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  // Entered at the first negedge after accept; lat = cycle index (1-based) where tvalid appears.
  task automatic recv_block(input int stall, output logic [63:0] d, output int lat);
    lat = 1;
    d = 'x;
    while (!m_axis_tvalid && lat < 200) begin @(negedge clk); lat++; end
    if (!m_axis_tvalid) begin
      checks++; errors++; $display("FAIL recv_timeout: m_axis_tvalid=0 after %0d cycles, expected 1", lat);
      return;
    end
    d = m_axis_tdata;
    if (stall > 0) begin
      m_axis_tready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || s_axis_tready !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: got tvalid=%b tdata=%h s_tready=%b, expected 1 %h 0",
                   m_axis_tvalid, m_axis_tdata, s_axis_tready, d);
        end
      end
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = idle_ready;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_done: got tvalid=%b s_tready=%b, expected 0 1", m_axis_tvalid, s_axis_tready);
    end
  endtask

  task automatic expect_block(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    do_reset(128'h0);
    checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: got s_tready=%b tvalid=%b tdata=%h, expected 0 0 0",
               s_axis_tready, m_axis_tvalid, m_axis_tdata);
    end
    wait_keygen("reset");
  endtask

  task automatic test_known_vector;
    logic [63:0] d;
    int lat;
    send_block(enc(64'h0123456789ABCDEF));
    recv_block(0, d, lat);
    expect_block("known_vector", d, 64'h0123456789ABCDEF);
    checks++;
    if (lat !== ROUNDS + 1) begin
      errors++; $display("FAIL latency: got %0d cycles, expected %0d", lat, ROUNDS + 1);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] p, d;
    int lat;
    p = {$urandom, $urandom};
    send_block(enc(p));
    recv_block(10, d, lat);
    expect_block("backpressure", d, p);
  endtask

  task automatic test_ready_idle;
    logic [63:0] p, d;
    int lat;
    idle_ready = 1'b1; m_axis_tready = 1'b1;
    p = {$urandom, $urandom};
    send_block(enc(p));
    recv_block(0, d, lat);
    expect_block("ready_idle", d, p);
    checks++;
    if (lat !== ROUNDS + 1) begin
      errors++; $display("FAIL ready_idle_latency: got %0d, expected %0d", lat, ROUNDS + 1);
    end
    idle_ready = 1'b0; m_axis_tready = 1'b0;
  endtask

  task automatic test_round_trip;
    logic [63:0] q[$];
    logic [63:0] p, d, exp;
    int lat;
    do_reset(128'h00112233445566778899AABBCCDDEEFF);
    wait_keygen("round_trip");
    for (int b = 0; b < 100; b++) begin
      p = {$urandom, $urandom};
      q.push_back(p);
      send_block(enc(p));
      recv_block(int'($urandom_range(0, 3)), d, lat);
      exp = q.pop_front();
      expect_block("round_trip", d, exp);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_ignore_during_round;
    logic [63:0] p, d;
    int lat, n;
    p = {$urandom, $urandom};
    send_block(enc(p));
    n = 0;
    while (!m_axis_tvalid && n < 200) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = {$urandom, $urandom};
      checks++;
      if (s_axis_tready !== 1'b0) begin
        errors++; $display("FAIL busy_tready: got %b, expected 0", s_axis_tready);
      end
      @(negedge clk);
      n++;
    end
    s_axis_tvalid = 1'b0;
    recv_block(0, d, lat);
    expect_block("ignore_during_round", d, p);
  endtask

  task automatic test_reset_midflight;
    logic [127:0] k2;
    logic [63:0] p, d;
    int lat, n;
    // Reset lands on the edge that would execute round 15.
    send_block(enc({$urandom, $urandom}));
    repeat (14) @(negedge clk);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    do_reset(k2);
    wait_keygen("rst_round");
    p = {$urandom, $urandom};
    send_block(enc(p));
    recv_block(0, d, lat);
    expect_block("rst_round_next", d, p);

    // Reset while a result is waiting in OUT.
    send_block(enc({$urandom, $urandom}));
    n = 0;
    while (!m_axis_tvalid && n < 200) begin @(negedge clk); n++; end
    do_reset(128'h0);
    wait_keygen("rst_out");
    repeat (3) begin
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        errors++; $display("FAIL rst_out_tvalid: got %b, expected 0", m_axis_tvalid);
      end
      @(negedge clk);
    end
    p = {$urandom, $urandom};
    send_block(enc(p));
    recv_block(1, d, lat);
    expect_block("rst_out_next", d, p);
  endtask

  initial begin
    test_reset;
    test_known_vector;
    test_backpressure;
    test_ready_idle;
    test_ignore_during_round;
    test_round_trip;
    test_reset_midflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
